usr_shift_reg: RTL and testbench

- Parametrised universal shift register; successor to the fixed 4-bit SISO.
- Supports hold, shift right/left, rotate right/left and parallel load, selected per cycle.
- Adds synchronous preset and clear, dual serial ports, and a frame-complete pulse after WIDTH consecutive shift/rotate operations.
- Used as a generic SISO/SIPO/PISO/PIPO building block in the sequential-circuits library.

---
 rtl/usr_shift_reg.sv | 113 +++++++++++
 tb/tb_usr_shift_reg.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/usr_shift_reg.sv
// Parametrised universal shift register: hold, shift/rotate left/right and parallel load.
// It also provides synchronous preset/clear and a one-cycle frame_done pulse after WIDTH shift operations.
module usr_shift_reg #(
  parameter int              WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter int              CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             preset,
  input  logic             clr,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] pout,
  output logic             sout_r,
  output logic             sout_l,
  output logic             frame_done
);

  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_ROR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_LOAD = 3'b101;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] pout_r;
  logic [WIDTH-1:0] pout_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             frame_done_r;
  logic             frame_done_nxt_s;
  logic             shifting_s;

  // Next-state selection with preset > clr > enabled mode > hold priority.
  always_comb begin
    pout_nxt_s       = pout_r;
    cnt_nxt_s        = cnt_r;
    frame_done_nxt_s = 1'b0;
    shifting_s       = 1'b0;
    if (preset) begin
      pout_nxt_s = {WIDTH{1'b1}};
      cnt_nxt_s  = CNT_ZERO;
    end else if (clr) begin
      pout_nxt_s = {WIDTH{1'b0}};
      cnt_nxt_s  = CNT_ZERO;
    end else if (en) begin
      case (mode)
        MODE_SHR: begin
          pout_nxt_s = {sin_l, pout_r[WIDTH-1:1]};
          shifting_s = 1'b1;
        end
        MODE_SHL: begin
          pout_nxt_s = {pout_r[WIDTH-2:0], sin_r};
          shifting_s = 1'b1;
        end
        MODE_ROR: begin
          pout_nxt_s = {pout_r[0], pout_r[WIDTH-1:1]};
          shifting_s = 1'b1;
        end
        MODE_ROL: begin
          pout_nxt_s = {pout_r[WIDTH-2:0], pout_r[WIDTH-1]};
          shifting_s = 1'b1;
        end
        MODE_LOAD: begin
          pout_nxt_s = pin;
          cnt_nxt_s  = CNT_ZERO;
        end
        default: begin
          pout_nxt_s = pout_r;
        end
      endcase
      // The frame counter ignores direction; it wraps on the edge that completes a frame.
      if (shifting_s) begin
        if (cnt_r == CNT_LAST) begin
          cnt_nxt_s        = CNT_ZERO;
          frame_done_nxt_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end else begin
        frame_done_nxt_s = 1'b0;
      end
    end else begin
      pout_nxt_s = pout_r;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pout_r       <= RESET_VAL;
      cnt_r        <= CNT_ZERO;
      frame_done_r <= 1'b0;
    end else begin
      pout_r       <= pout_nxt_s;
      cnt_r        <= cnt_nxt_s;
      frame_done_r <= frame_done_nxt_s;
    end
  end

  assign pout       = pout_r;
  assign frame_done = frame_done_r;
  assign sout_r     = pout_r[0];
  assign sout_l     = pout_r[WIDTH-1];

endmodule

// File: tb/tb_usr_shift_reg.sv
// Self-checking bench for usr_shift_reg: a WIDTH=4 instance and a WIDTH=8/RESET_VAL=A5 instance.
// It applies directed vectors, hand-written corner sequences and random stimulus checked against an arithmetic model.
module tb_usr_shift_reg;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] mode;
  logic       preset;
  logic       clr;
  logic       sin_l;
  logic       sin_r;
  logic [3:0] pin4;
  logic [7:0] pin8;
  logic [3:0] pout4;
  logic [7:0] pout8;
  logic       sout_r4, sout_l4, fd4;
  logic       sout_r8, sout_l8, fd8;

  int pass_cnt  = 0;
  int total_cnt = 0;

  usr_shift_reg #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .preset(preset), .clr(clr),
    .sin_l(sin_l), .sin_r(sin_r), .pin(pin4), .pout(pout4),
    .sout_r(sout_r4), .sout_l(sout_l4), .frame_done(fd4)
  );

  usr_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .preset(preset), .clr(clr),
    .sin_l(sin_l), .sin_r(sin_r), .pin(pin8), .pout(pout8),
    .sout_r(sout_r8), .sout_l(sout_l8), .frame_done(fd8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [2:0] mode;
    logic       preset;
    logic       clr;
    logic       sin_l;
    logic       sin_r;
    logic [3:0] pin;
    logic [3:0] exp_pout;
    logic       exp_fd;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: register value as an integer, shift count as a plain tally toward w.
  task automatic model(input int w, input int pin_v, inout int v, inout int c, output int fd);
    int mask;
    bit shifted;
    mask    = (1 << w) - 1;
    fd      = 0;
    shifted = 1'b0;
    if (preset) begin
      v = mask; c = 0;
    end else if (clr) begin
      v = 0; c = 0;
    end else if (en) begin
      case (mode)
        3'd1: begin v = (v >> 1) | (int'(sin_l) << (w - 1)); shifted = 1'b1; end
        3'd2: begin v = ((v << 1) | int'(sin_r)) & mask; shifted = 1'b1; end
        3'd3: begin v = (v >> 1) | ((v & 1) << (w - 1)); shifted = 1'b1; end
        3'd4: begin v = ((v << 1) | (v >> (w - 1))) & mask; shifted = 1'b1; end
        3'd5: begin v = pin_v & mask; c = 0; end
        default: ;
      endcase
      if (shifted) begin
        c++;
        if (c == w) begin fd = 1; c = 0; end
      end
    end
  endtask

  initial begin
    int v4, c4, v8, c8, f4, f8;
    rst = 1'b1; en = 1'b0; mode = 3'b000; preset = 1'b0; clr = 1'b0;
    sin_l = 1'b0; sin_r = 1'b0; pin4 = 4'h0; pin8 = 8'h3C;

    // Asynchronous reset asserted between edges takes effect immediately.
    tick(); tick();
    rst = 1'b0;
    #2;
    check("async_rst pout4", int'(pout4), 'h0);
    check("async_rst fd4", int'(fd4), 0);
    check("async_rst pout8", int'(pout8), 'hA5);
    tick();
    rst = 1'b1;
    tick();
    check("idle_after_rst pout4", int'(pout4), 'h0);
    check("idle_after_rst pout8", int'(pout8), 'hA5);

    // Directed WIDTH=4 vectors: {en, mode, preset, clr, sin_l, sin_r, pin, exp_pout, exp_fd}
    vecs.push_back('{1'b1, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1011, 4'b1011, 1'b0});
    vecs.push_back('{1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1101, 1'b0});
    vecs.push_back('{1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0110, 1'b0});
    vecs.push_back('{1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0011, 1'b0});
    vecs.push_back('{1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1001, 1'b1});
    vecs.push_back('{1'b1, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 4'b1000, 1'b0});
    for (int k = 0; k < 2; k++) begin
      vecs.push_back('{1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0});
      vecs.push_back('{1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0010, 1'b0});
      vecs.push_back('{1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0100, 1'b0});
      vecs.push_back('{1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b1000, 1'b1});
    end
    vecs.push_back('{1'b1, 3'b101, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0101, 4'b1111, 1'b0});
    vecs.push_back('{1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0});
    vecs.push_back('{1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0001, 1'b0});
    vecs.push_back('{1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0011, 1'b0});
    vecs.push_back('{1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0111, 1'b0});
    vecs.push_back('{1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0111, 1'b0});
    vecs.push_back('{1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0111, 1'b0});
    vecs.push_back('{1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b1110, 1'b1});
    vecs.push_back('{1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b1101, 1'b0});
    vecs.push_back('{1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b1011, 1'b0});
    vecs.push_back('{1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0111, 1'b0});
    vecs.push_back('{1'b1, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0});
    vecs.push_back('{1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1000, 1'b0});
    vecs.push_back('{1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1100, 1'b0});
    vecs.push_back('{1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1110, 1'b0});
    vecs.push_back('{1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1111, 1'b1});
    vecs.push_back('{1'b1, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b1111, 1'b0});

    foreach (vecs[i]) begin
      en = vecs[i].en; mode = vecs[i].mode; preset = vecs[i].preset; clr = vecs[i].clr;
      sin_l = vecs[i].sin_l; sin_r = vecs[i].sin_r; pin4 = vecs[i].pin;
      tick();
      check($sformatf("vec%0d pout", i), int'(pout4), int'(vecs[i].exp_pout));
      check($sformatf("vec%0d frame_done", i), int'(fd4), int'(vecs[i].exp_fd));
      check($sformatf("vec%0d sout_r", i), int'(sout_r4), int'(vecs[i].exp_pout[0]));
      check($sformatf("vec%0d sout_l", i), int'(sout_l4), int'(vecs[i].exp_pout[3]));
    end

    // Asynchronous reset in the middle of activity.
    en = 1'b0; mode = 3'b000; preset = 1'b0; clr = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    check("midrun_rst pout4", int'(pout4), 'h0);
    check("midrun_rst pout8", int'(pout8), 'hA5);
    tick();
    rst = 1'b1;
    tick();

    // WIDTH=8: reserved modes hold, then a full frame of right shifts with sin_l=0.
    en = 1'b1; mode = 3'b110;
    tick();
    check("w8 mode110 pout", int'(pout8), 'hA5);
    mode = 3'b111;
    tick();
    check("w8 mode111 pout", int'(pout8), 'hA5);
    check("w8 mode111 fd", int'(fd8), 0);
    mode = 3'b001; sin_l = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("w8 shr%0d pout", i), int'(pout8), 'hA5 >> (i + 1));
      check($sformatf("w8 shr%0d fd", i), int'(fd8), (i == 7) ? 1 : 0);
    end

    // Randomised phase against the reference model, both widths at once.
    en = 1'b0; mode = 3'b000;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    v4 = 0; c4 = 0; v8 = 'hA5; c8 = 0;
    for (int n = 0; n < 600; n++) begin
      preset = ($urandom_range(0, 24) == 0);
      clr    = ($urandom_range(0, 24) == 0);
      en     = ($urandom_range(0, 7) != 0);
      mode   = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) mode = 3'($urandom_range(1, 4));
      sin_l  = 1'($urandom_range(0, 1));
      sin_r  = 1'($urandom_range(0, 1));
      pin4   = 4'($urandom_range(0, 15));
      pin8   = 8'($urandom_range(0, 255));
      model(4, int'(pin4), v4, c4, f4);
      model(8, int'(pin8), v8, c8, f8);
      tick();
      check($sformatf("rnd%0d pout4", n), int'(pout4), v4);
      check($sformatf("rnd%0d fd4", n), int'(fd4), f4);
      check($sformatf("rnd%0d sout_r4", n), int'(sout_r4), v4 & 1);
      check($sformatf("rnd%0d sout_l4", n), int'(sout_l4), (v4 >> 3) & 1);
      check($sformatf("rnd%0d pout8", n), int'(pout8), v8);
      check($sformatf("rnd%0d fd8", n), int'(fd8), f8);
      check($sformatf("rnd%0d sout_r8", n), int'(sout_r8), v8 & 1);
      check($sformatf("rnd%0d sout_l8", n), int'(sout_l8), (v8 >> 7) & 1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
